apb_master_bridge: RTL and testbench

- APB requester (initiator) for the peripheral bus. It turns single-beat commands from a local valid/ready request port into APB SETUP/ACCESS transfers toward APB completers such as the 8-bit RAM completer.
- It returns read data and error status on a one-cycle response strobe.
- Adds a local address-range check and a PREADY wait-state timeout, so a hung or out-of-range completer never stalls the requester.

---
 rtl/apb_master_bridge_if.sv | 30 +++
 rtl/apb_master_bridge.sv | 101 ++++++++++
 tb/tb_apb_master_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: local request/response port plus APB bus signals of the bridge
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-beat APB requester with address range check and PREADY timeout
module apb_master_bridge #(
    parameter int              ADDR_WIDTH     = 8,
    parameter int              DATA_WIDTH     = 8,
    parameter longint unsigned MAX_ADDR       = (64'd1 << ADDR_WIDTH) - 64'd1,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input logic                  PCLK,
    input logic                  PRESET,
    apb_master_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, LERR} state_t;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n, cnt_inc;
    logic                  accept, in_range;
    logic                  psel_n, penable_n, pwrite_n, rsp_valid_n, rsp_err_n;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic [DATA_WIDTH-1:0] pwdata_n, rsp_rdata_n;

    assign bus.req_ready = (state == IDLE) && !PRESET;
    assign accept        = bus.req_valid && bus.req_ready;
    assign in_range      = 64'(bus.req_addr) <= MAX_ADDR;
    assign cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // next state and next register values; everything not touched holds
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        psel_n      = bus.PSEL;
        penable_n   = bus.PENABLE;
        pwrite_n    = bus.PWRITE;
        paddr_n     = bus.PADDR;
        pwdata_n    = bus.PWDATA;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = bus.rsp_rdata;
        rsp_err_n   = bus.rsp_err;
        case (state)
            IDLE: if (accept) begin
                if (in_range) begin
                    state_n   = SETUP;
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                    pwrite_n  = bus.req_write;
                    paddr_n   = bus.req_addr;
                    pwdata_n  = bus.req_wdata;
                end else begin
                    state_n     = LERR;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
                cnt_n     = '0;
            end
            ACCESS: begin
                cnt_n = bus.PREADY ? cnt : cnt_inc;
                if (bus.PREADY || (TIMEOUT_CYCLES != 0 && cnt_inc == CW'(TIMEOUT_CYCLES))) begin
                    state_n     = IDLE;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = bus.PREADY ? bus.PSLVERR : 1'b1;
                    rsp_rdata_n = (bus.PREADY && !bus.PSLVERR && !bus.PWRITE) ? bus.PRDATA : '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; reset aborts any transfer without a response
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bus.PSEL      <= psel_n;
            bus.PENABLE   <= penable_n;
            bus.PWRITE    <= pwrite_n;
            bus.PADDR     <= paddr_n;
            bus.PWDATA    <= pwdata_n;
            bus.rsp_valid <= rsp_valid_n;
            bus.rsp_rdata <= rsp_rdata_n;
            bus.rsp_err   <= rsp_err_n;
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and random transfers checked against a transaction-level model
module tb_apb_master_bridge;
    localparam int TO  = 16;
    localparam int MAX = 127;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int   ncmp = 0;
    int   nerr = 0;
    int   waits_cfg = 0;
    bit   err_cfg = 1'b0;
    int   wait_cnt = 0;
    logic rdy;
    logic [7:0] comp_mem [256];
    bit         comp_vld [256];
    logic [7:0] ref_mem  [256];

    apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus();

    apb_master_bridge #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_ADDR(64'h7F), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [7:0] seed(input logic [7:0] a);
        return 8'(a * 7 + 3);
    endfunction

    // completer: waits_cfg wait states, PSLVERR forced high during wait states
    assign rdy         = bus.PSEL && bus.PENABLE && (wait_cnt >= waits_cfg);
    assign bus.PREADY  = rdy;
    assign bus.PSLVERR = rdy ? err_cfg : 1'b1;
    assign bus.PRDATA  = comp_vld[bus.PADDR] ? comp_mem[bus.PADDR] : seed(bus.PADDR);

    // completer wait counter and memory
    always @(posedge PCLK) begin
        wait_cnt <= (bus.PSEL && !bus.PENABLE) ? 0 : (bus.PSEL && bus.PENABLE && !rdy) ? wait_cnt + 1 : wait_cnt;
        if (rdy && bus.PWRITE && !err_cfg) begin
            comp_mem[bus.PADDR] <= bus.PWDATA;
            comp_vld[bus.PADDR] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input bit w, input logic [7:0] a, input logic [7:0] d, input int wt, input bit e);
        int lat, ps, pe, bad, exp_lat;
        bit inr, exp_err;
        logic [7:0] exp_rd;
        inr     = int'(a) <= MAX;
        exp_lat = !inr ? 1 : (wt >= TO ? 2 + TO : 3 + wt);
        exp_err = !inr || wt >= TO || e;
        exp_rd  = (exp_err || w) ? 8'h00 : ref_mem[a];
        if (!exp_err && w) ref_mem[a] = d;
        waits_cfg = wt;
        err_cfg   = e;
        @(negedge PCLK);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge PCLK);
        #1 bus.req_valid = 1'b0;
        lat = 1; ps = 0; pe = 0; bad = 0;
        @(negedge PCLK);
        while (!bus.rsp_valid && lat < 60) begin
            if (bus.PSEL) begin
                ps++;
                if (bus.PADDR !== a || bus.PWRITE !== w || bus.PWDATA !== d) bad++;
            end
            if (bus.PENABLE) pe++;
            @(negedge PCLK);
            lat++;
        end
        check("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        check("psel_cycles", 32'(ps), inr ? 32'(exp_lat - 1) : 32'd0);
        check("penable_cycles", 32'(pe), inr ? 32'(exp_lat - 2) : 32'd0);
        check("apb_stable", 32'(bad), 32'd0);
        check("psel_at_rsp", 32'(bus.PSEL), 32'd0);
        if (inr) check("ready_at_rsp", 32'(bus.req_ready), 32'd1);
        @(negedge PCLK);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int n, r, wt;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(8'(i));
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_psel", 32'(bus.PSEL), 32'd0);
        check("rst_penable", 32'(bus.PENABLE), 32'd0);
        check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        check("rst_paddr", 32'(bus.PADDR), 32'd0);
        check("rst_pwdata", 32'(bus.PWDATA), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        PRESET = 1'b0;
        do_txn(1'b1, 8'h05, 8'hA5, 0, 1'b0);
        do_txn(1'b0, 8'h05, 8'h00, 0, 1'b0);
        do_txn(1'b1, 8'h10, 8'h3C, 0, 1'b0);
        do_txn(1'b0, 8'h10, 8'h11, 4, 1'b0);
        do_txn(1'b0, 8'h20, 8'h22, 0, 1'b1);
        do_txn(1'b0, 8'h21, 8'h00, 2, 1'b1);
        do_txn(1'b0, 8'h30, 8'h00, TO, 1'b0);
        do_txn(1'b0, 8'h31, 8'h00, TO - 1, 1'b0);
        do_txn(1'b1, 8'h80, 8'h5A, 0, 1'b0);
        do_txn(1'b0, 8'hFF, 8'h00, 0, 1'b0);
        waits_cfg = 10;
        err_cfg   = 1'b0;
        @(negedge PCLK);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h40;
        @(posedge PCLK);
        #1 bus.req_valid = 1'b0;
        n = 0;
        @(negedge PCLK);
        while (!bus.PENABLE && n < 10) begin
            @(negedge PCLK);
            n++;
        end
        check("penable_before_reset", 32'(bus.PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("abort_psel", 32'(bus.PSEL), 32'd0);
        check("abort_penable", 32'(bus.PENABLE), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("post_reset_ready", 32'(bus.req_ready), 32'd1);
        check("post_reset_no_rsp", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            wt = (r < 5) ? 0 : (r < 8) ? r - 4 : (r == 8) ? TO : TO - 1;
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            do_txn(1'($urandom_range(0, 1)), a, 8'($urandom), wt, $urandom_range(0, 5) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
